// File: rtl/food_placer_pkg.sv
// -----------------------------------------------------------------------------
// food_placer_pkg
// Shared playfield constants and the food placer FSM state encoding.
//   COORD_W        : width of a cell coordinate (covers up to 32 cells)
//   GRID_W_DEF     : default playfield width in cells
//   GRID_H_DEF     : default playfield height in cells
//   MAX_TRIES_DEF  : default number of random candidates before the scan
//   TRY_CNT_W      : width of the random-try counter
//   SCAN_CNT_W     : width of the scan counter (holds 32*32 = 1024)
// -----------------------------------------------------------------------------
package food_placer_pkg;

  localparam int COORD_W       = 5;
  localparam int GRID_W_DEF    = 16;
  localparam int GRID_H_DEF    = 16;
  localparam int MAX_TRIES_DEF = 4;
  localparam int TRY_CNT_W     = 4;
  localparam int SCAN_CNT_W    = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMP_Y = 3'd1,
    ST_QUERY  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SCAN_Q = 3'd4,
    ST_SCAN_W = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/food_placer_coord_fold.sv
// -----------------------------------------------------------------------------
// coord_fold
// Folds a 5-bit random sample into the range 0..G-1 with one conditional
// subtraction. Because G is at least 16, a 5-bit sample is never more than
// one grid span above the limit, so a single subtract is always enough.
// Ports:
//   r     : raw random sample
//   coord : folded coordinate, 0..G-1
// -----------------------------------------------------------------------------
module coord_fold
  import food_placer_pkg::*;
#(
  parameter int G = 16
) (
  input  logic [COORD_W-1:0] r,
  output logic [COORD_W-1:0] coord
);

  // One extra bit so that G = 32 is representable in the compare.
  localparam logic [COORD_W:0] G_EXT = (COORD_W+1)'(G);

  logic [COORD_W:0] r_ext;

  assign r_ext = {1'b0, r};
  assign coord = (r_ext >= G_EXT) ? COORD_W'(r_ext - G_EXT) : r;

endmodule

// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
// Turns random samples into a free food cell on the playfield. On req it draws
// x then y from rand_num, asks the snake occupancy map about the candidate,
// retries with fresh random candidates up to MAX_TRIES times, then walks the
// board linearly from the last candidate until a free cell is found or every
// cell has been tried (board full).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req               : one-cycle request to place new food
//   rand_num          : free-running random source, new value every clk
//   occ_x/occ_y       : occupancy query coordinate
//   occ_vld           : one-cycle query strobe
//   occ_hit           : answer for the query, valid the cycle after occ_vld
//   food_x/food_y     : placed food coordinate
//   food_vld          : high while food_x/food_y hold a placed food
//   done              : one-cycle pulse when placement finishes (also on full)
//   board_full        : sticky, no free cell found on the last placement
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for req; x of the first candidate is sampled on req
// SAMP_Y  | sample y of the candidate, launch its query
// QUERY   | query strobe on the occupancy map
// WAIT    | occupancy answer arrives; accept, retry randomly, or start scan
// SCAN_Q  | query strobe for the current scan cell
// SCAN_W  | scan answer arrives; accept, step to next cell, or declare full
// FIN     | food registered, done pulse
//
// All outputs are registered and set on the transition into the state that
// owns them, so occ_vld is high while in QUERY/SCAN_Q and done is high while
// in FIN (or in the IDLE cycle right after a board-full verdict).
// -----------------------------------------------------------------------------
module food_placer
  import food_placer_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [COORD_W-1:0] rand_num,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  output logic               occ_vld,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_vld,
  output logic               done,
  output logic               board_full
);

  localparam logic [COORD_W-1:0]    X_LAST  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0]    Y_LAST  = COORD_W'(GRID_H - 1);
  localparam logic [TRY_CNT_W-1:0]  TRY_LIM = TRY_CNT_W'(MAX_TRIES);
  localparam logic [SCAN_CNT_W-1:0] CELLS   = SCAN_CNT_W'(GRID_W * GRID_H);

  state_t                  state;
  logic [COORD_W-1:0]      cand_x;
  logic [COORD_W-1:0]      cand_y;
  logic [COORD_W-1:0]      fold_x;
  logic [COORD_W-1:0]      fold_y;
  logic [COORD_W-1:0]      adv_x;
  logic [COORD_W-1:0]      adv_y;
  logic [TRY_CNT_W-1:0]    try_cnt;
  logic [SCAN_CNT_W-1:0]   scan_cnt;

  coord_fold #(.G(GRID_W)) u_fold_x (
    .r     (rand_num),
    .coord (fold_x)
  );

  coord_fold #(.G(GRID_H)) u_fold_y (
    .r     (rand_num),
    .coord (fold_y)
  );

  // Raster-order successor of the current candidate, wrapping at the corner.
  always_comb begin
    adv_x = cand_x + 1'b1;
    adv_y = cand_y;
    if (cand_x == X_LAST) begin
      adv_x = '0;
      adv_y = (cand_y == Y_LAST) ? '0 : cand_y + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      try_cnt    <= '0;
      scan_cnt   <= '0;
      occ_x      <= '0;
      occ_y      <= '0;
      occ_vld    <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_vld   <= 1'b0;
      done       <= 1'b0;
      board_full <= 1'b0;
    end else begin
      occ_vld <= 1'b0;
      done    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            cand_x     <= fold_x;
            food_vld   <= 1'b0;
            board_full <= 1'b0;
            try_cnt    <= '0;
            state      <= ST_SAMP_Y;
          end
        end

        ST_SAMP_Y: begin
          // y comes from the sample after x, so the two are independent.
          cand_y  <= fold_y;
          occ_x   <= cand_x;
          occ_y   <= fold_y;
          occ_vld <= 1'b1;
          state   <= ST_QUERY;
        end

        ST_QUERY: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!occ_hit) begin
            food_x   <= cand_x;
            food_y   <= cand_y;
            food_vld <= 1'b1;
            done     <= 1'b1;
            state    <= ST_FIN;
          end else if ((try_cnt + 1'b1) < TRY_LIM) begin
            try_cnt <= try_cnt + 1'b1;
            cand_x  <= fold_x;
            state   <= ST_SAMP_Y;
          end else begin
            scan_cnt <= '0;
            cand_x   <= adv_x;
            cand_y   <= adv_y;
            occ_x    <= adv_x;
            occ_y    <= adv_y;
            occ_vld  <= 1'b1;
            state    <= ST_SCAN_Q;
          end
        end

        ST_SCAN_Q: begin
          state <= ST_SCAN_W;
        end

        ST_SCAN_W: begin
          if (!occ_hit) begin
            food_x   <= cand_x;
            food_y   <= cand_y;
            food_vld <= 1'b1;
            done     <= 1'b1;
            state    <= ST_FIN;
          end else if ((scan_cnt + 1'b1) == CELLS) begin
            // Every cell answered occupied: report full, leave food_vld low.
            scan_cnt   <= scan_cnt + 1'b1;
            board_full <= 1'b1;
            done       <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
            cand_x   <= adv_x;
            cand_y   <= adv_y;
            occ_x    <= adv_x;
            occ_y    <= adv_y;
            occ_vld  <= 1'b1;
            state    <= ST_SCAN_Q;
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
// Three placers share clk/rst/rand_num: A 16x16 with 4 tries, B 16x16 with
// 2 tries, C 20x20 with 4 tries. Each has its own req and an occupancy
// responder backed by a per-placer cell map plus an optional "first N queries
// are hits" override. Expected results come from a placement model working on
// linear cell indices and the pre-generated random stream.
// -----------------------------------------------------------------------------
module tb_food_placer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rand_num;
  logic       req      [3];
  logic       occ_hit  [3];
  logic [4:0] occ_x    [3];
  logic [4:0] occ_y    [3];
  logic       occ_vld  [3];
  logic [4:0] food_x   [3];
  logic [4:0] food_y   [3];
  logic       food_vld [3];
  logic       done     [3];
  logic       board_full [3];

  always #5 clk = ~clk;

  food_placer #(.GRID_W(16), .GRID_H(16), .MAX_TRIES(4)) u_a (
    .clk(clk), .rst(rst), .req(req[0]), .rand_num(rand_num),
    .occ_x(occ_x[0]), .occ_y(occ_y[0]), .occ_vld(occ_vld[0]), .occ_hit(occ_hit[0]),
    .food_x(food_x[0]), .food_y(food_y[0]), .food_vld(food_vld[0]),
    .done(done[0]), .board_full(board_full[0]));

  food_placer #(.GRID_W(16), .GRID_H(16), .MAX_TRIES(2)) u_b (
    .clk(clk), .rst(rst), .req(req[1]), .rand_num(rand_num),
    .occ_x(occ_x[1]), .occ_y(occ_y[1]), .occ_vld(occ_vld[1]), .occ_hit(occ_hit[1]),
    .food_x(food_x[1]), .food_y(food_y[1]), .food_vld(food_vld[1]),
    .done(done[1]), .board_full(board_full[1]));

  food_placer #(.GRID_W(20), .GRID_H(20), .MAX_TRIES(4)) u_c (
    .clk(clk), .rst(rst), .req(req[2]), .rand_num(rand_num),
    .occ_x(occ_x[2]), .occ_y(occ_y[2]), .occ_vld(occ_vld[2]), .occ_hit(occ_hit[2]),
    .food_x(food_x[2]), .food_y(food_y[2]), .food_vld(food_vld[2]),
    .done(done[2]), .board_full(board_full[2]));

  int checks   = 0;
  int failures = 0;
  int rs [1200];
  bit occ_map [3][32][32];
  int hb [3];
  bit pend [3];
  int cur_d;
  int act_q [$];
  int exp_q [$];

  typedef struct {
    int d;
    int rx;
    int ry;
    int ex;
    int ey;
  } vec_t;

  function automatic int gw(input int d);
    return (d == 2) ? 20 : 16;
  endfunction

  function automatic int gh(input int d);
    return (d == 2) ? 20 : 16;
  endfunction

  function automatic int gm(input int d);
    return (d == 1) ? 2 : 4;
  endfunction

  function automatic int fold(input int r, input int g);
    return (r >= g) ? r - g : r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Occupancy map: an answer is presented during the cycle after the strobe.
  task automatic respond();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        pend[d]    = 1'b0;
        occ_hit[d] = 1'b0;
      end else begin
        occ_hit[d] = pend[d];
        if (occ_vld[d]) begin
          if (d == cur_d) act_q.push_back(int'(occ_x[d]) * 64 + int'(occ_y[d]));
          if (d == cur_d && act_q.size() <= hb[d]) pend[d] = 1'b1;
          else pend[d] = occ_map[d][occ_x[d]][occ_y[d]];
        end else begin
          pend[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
  endtask

  task automatic fill_map(input int d, input int dens);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        occ_map[d][x][y] = ($urandom_range(0, 99) < dens);
  endtask

  task automatic fill_rs();
    for (int i = 0; i < 1200; i++) rs[i] = $urandom_range(0, 31);
  endtask

  // Placement model over linear cell indices. Cycle numbers count from the
  // req cycle as cycle 0.
  function automatic void model(input int d, input int hbv, output int e_cyc,
                                output int e_fx, output int e_fy,
                                output int e_vld, output int e_full);
    int w, h, m, x, y, q, cells, idx, c;
    bit occ;
    w = gw(d); h = gh(d); m = gm(d);
    exp_q.delete();
    q = 0; x = 0; y = 0;
    e_cyc = 0; e_fx = 0; e_fy = 0; e_vld = 0; e_full = 0;
    for (int k = 0; k < m; k++) begin
      x = fold(rs[3*k], w);
      y = fold(rs[3*k+1], h);
      exp_q.push_back(x * 64 + y);
      occ = (q < hbv) ? 1'b1 : occ_map[d][x][y];
      q++;
      if (!occ) begin
        e_cyc = 3*k + 4; e_fx = x; e_fy = y; e_vld = 1;
        return;
      end
    end
    cells = w * h;
    idx   = y * w + x;
    for (int s = 1; s <= cells; s++) begin
      c = (idx + s) % cells;
      x = c % w;
      y = c / w;
      exp_q.push_back(x * 64 + y);
      occ = (q < hbv) ? 1'b1 : occ_map[d][x][y];
      q++;
      if (!occ) begin
        e_cyc = 3*m + 2*s + 1; e_fx = x; e_fy = y; e_vld = 1;
        return;
      end
    end
    e_cyc  = 3*m + 2*cells + 1;
    e_full = 1;
  endfunction

  // Issue req (and optionally a second req at cycle extra_req), run until a
  // few cycles past done or the cycle budget, then compare with the model.
  task automatic run_case(input int d, input int hbv, input int extra_req,
                          output int dcyc, output int ndone, output int nq);
    int budget, e_cyc, e_fx, e_fy, e_vld, e_full, mism;
    budget = 3*gm(d) + 2*gw(d)*gh(d) + 12;
    cur_d  = d;
    hb[d]  = hbv;
    act_q.delete();
    dcyc  = -1;
    ndone = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      rand_num = 5'(rs[i]);
      req[d]   = (i == 0) || (i == extra_req);
      if (done[d]) begin
        ndone++;
        if (dcyc < 0) dcyc = i;
      end
      if (dcyc >= 0 && i >= dcyc + 3) break;
    end
    req[d] = 1'b0;
    nq = act_q.size();
    model(d, hbv, e_cyc, e_fx, e_fy, e_vld, e_full);
    chk("done_cycle", dcyc, e_cyc);
    chk("done_count", ndone, 1);
    chk("food_vld", int'(food_vld[d]), e_vld);
    chk("board_full", int'(board_full[d]), e_full);
    if (e_vld == 1) begin
      chk("food_x", int'(food_x[d]), e_fx);
      chk("food_y", int'(food_y[d]), e_fy);
    end
    chk("query_count", nq, exp_q.size());
    mism = -1;
    for (int i = 0; i < nq && i < exp_q.size(); i++)
      if (mism < 0 && act_q[i] != exp_q[i]) mism = i;
    chk("query_seq_first_bad", mism, -1);
  endtask

  vec_t vecs [6];

  initial begin
    int dcyc, ndone, nq, dens, d, sum;

    vecs[0] = '{0,  9, 20,  9,  4};
    vecs[1] = '{0, 31, 16, 15,  0};
    vecs[2] = '{0, 16, 15,  0, 15};
    vecs[3] = '{0, 15,  0, 15,  0};
    vecs[4] = '{2, 19, 20, 19,  0};
    vecs[5] = '{2, 20, 31,  0, 11};

    rst = 1'b1;
    rand_num = '0;
    cur_d = 0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; occ_hit[i] = 1'b0; hb[i] = 0; pend[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      sum = int'({occ_x[i], occ_y[i], occ_vld[i], food_x[i], food_y[i],
                  food_vld[i], done[i], board_full[i]});
      chk("reset_outputs", sum, 0);
    end
    rst = 1'b0;
    tick();

    // Directed fold / free-first-try vectors.
    foreach (vecs[v]) begin
      fill_map(vecs[v].d, 0);
      fill_rs();
      rs[0] = vecs[v].rx;
      rs[1] = vecs[v].ry;
      run_case(vecs[v].d, 0, -1, dcyc, ndone, nq);
      chk("vec_food_x", int'(food_x[vecs[v].d]), vecs[v].ex);
      chk("vec_food_y", int'(food_y[vecs[v].d]), vecs[v].ey);
      chk("vec_done_cycle", dcyc, 4);
    end

    // Two random retries, then free.
    fill_map(0, 0);
    fill_rs();
    run_case(0, 2, -1, dcyc, ndone, nq);
    chk("retry_done_cycle", dcyc, 10);
    chk("retry_queries", nq, 3);

    // Scan fallback on the 2-try placer wrapping from (15,15) to (0,0).
    fill_map(1, 100);
    occ_map[1][0][0] = 1'b0;
    fill_rs();
    rs[0] = 5; rs[3] = 15; rs[4] = 31;
    run_case(1, 0, -1, dcyc, ndone, nq);
    chk("scan_food_x", int'(food_x[1]), 0);
    chk("scan_food_y", int'(food_y[1]), 0);
    chk("scan_done_cycle", dcyc, 9);

    // Board full, then a following req clears board_full.
    fill_map(0, 100);
    fill_rs();
    run_case(0, 0, -1, dcyc, ndone, nq);
    chk("full_queries", nq, 4 + 256);
    chk("full_flag", int'(board_full[0]), 1);
    fill_map(0, 0);
    fill_rs();
    run_case(0, 0, -1, dcyc, ndone, nq);
    chk("full_cleared", int'(board_full[0]), 0);

    // req during WAIT is ignored.
    fill_map(0, 0);
    fill_rs();
    run_case(0, 0, 3, dcyc, ndone, nq);
    chk("wait_req_queries", nq, 1);

    // Reset while B sits in SCAN_Q of its second scan step.
    fill_map(1, 100);
    fill_rs();
    cur_d = 1;
    hb[1] = 0;
    act_q.delete();
    ndone = 0;
    for (int i = 0; i <= 9; i++) begin
      tick();
      rand_num = 5'(rs[i]);
      req[1] = (i == 0);
      if (done[1]) ndone++;
    end
    req[1] = 1'b0;
    chk("scanq_strobe", int'(occ_vld[1]), 1);
    rst = 1'b1;
    #1;
    sum = int'({occ_x[1], occ_y[1], occ_vld[1], food_x[1], food_y[1],
                food_vld[1], done[1], board_full[1]});
    chk("midscan_reset_outputs", sum, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done[1]) ndone++;
    end
    chk("midscan_no_done", ndone, 0);
    fill_map(1, 0);
    fill_rs();
    run_case(1, 0, -1, dcyc, ndone, nq);
    chk("after_reset_done_cycle", dcyc, 4);

    // Randomized placements against the model.
    for (int it = 0; it < 14; it++) begin
      d = (it % 3);
      case ($urandom_range(0, 4))
        0: dens = 0;
        1: dens = 40;
        2: dens = 80;
        3: dens = 97;
        default: dens = 100;
      endcase
      fill_map(d, dens);
      fill_rs();
      run_case(d, $urandom_range(0, 1), -1, dcyc, ndone, nq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Consumer of the 5-bit free-running random source (rand_num). Turns random samples into a legal food coordinate on the LED-array playfield.
- On request from the game FSM it:
  - draws a random x, then a random y;
  - asks the snake occupancy map whether that cell is occupied;
  - retries a bounded number of times, then falls back to a deterministic scan.
- Output is a registered food position that feeds the display and collision logic.

Parameters:
- GRID_W, 16, playfield width in cells; legal range 16..32.
- GRID_H, 16, playfield height in cells; legal range 16..32.
- MAX_TRIES, 4, random candidates attempted before the linear scan starts; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  single-cycle pulse: place new food (game start / food eaten)
- rand_num  in  5  random value from the random source; changes every clk
- occ_x  out  5  query column
- occ_y  out  5  query row
- occ_vld  out  1  query strobe, one cycle per query
- occ_hit  in  1  occupancy answer, valid exactly 1 cycle after occ_vld; 1 = cell occupied by snake
- food_x  out  5  placed food column
- food_y  out  5  placed food row
- food_vld  out  1  level; high while food_x/food_y hold a placed food
- done  out  1  single-cycle pulse when placement completes, including the board-full case
- board_full  out  1  sticky; set when no free cell exists; cleared by rst or the next accepted req

Behaviour:
- Reset (async, rst=1): state IDLE; food_x=0, food_y=0, food_vld=0, done=0, board_full=0, occ_vld=0, occ_x=0, occ_y=0, try count=0, scan count=0. Reset mid-operation aborts with no done pulse.
- Range fold: coord = (r >= G) ? r - G : r, where r = rand_num and G = GRID_W or GRID_H. A single subtraction suffices because G >= 16.
- FSM states: IDLE, SAMP_Y, QUERY, WAIT, SCAN_Q, SCAN_W, FIN.
- IDLE:
  - req=1 → capture folded x from rand_num, clear food_vld and board_full, try count=0 → SAMP_Y.
  - req in any other state is ignored (no queuing).
- SAMP_Y: capture folded y from rand_num (the next cycle's value, so independent of x) → QUERY.
- QUERY: occ_x/occ_y = candidate, occ_vld=1 for one cycle → WAIT.
- WAIT: sample occ_hit.
  - 0 → FIN.
  - 1 and try count+1 < MAX_TRIES → increment try count, capture new folded x from rand_num → SAMP_Y.
  - 1 and tries exhausted → scan count=0, advance candidate (see SCAN rules) → SCAN_Q.
- SCAN advance: x+1; if x was GRID_W-1 then x=0 and y+1; if y was GRID_H-1 then y wraps to 0.
- SCAN_Q: issue query with occ_vld=1 → SCAN_W.
- SCAN_W:
  - occ_hit=0 → FIN.
  - Else increment scan count. If scan count reaches GRID_W*GRID_H → board_full=1, done=1, food_vld stays 0 → IDLE. Otherwise advance candidate → SCAN_Q.
- FIN: food_x/food_y = candidate, food_vld=1, done=1 for one cycle → IDLE.
- Latency:
  - Free first candidate: req at cycle 0 → done at cycle 4 (SAMP_Y c1, QUERY c2, WAIT c3, FIN c4).
  - Each random retry adds 3 cycles.
  - Each scan step adds 2 cycles.
- Outputs are registered. The occupancy map may hold stale data during placement; that is the caller's responsibility.
- Counter widths: scan count is 11 bits, enough for 32*32 = 1024 cells. Try count is 4 bits.

Decomposition:
- Shared game package holds the playfield constants (GRID_W/GRID_H defaults, COORD_W=5) and the FSM state encoding.
- One natural sub-module, coord_fold: the combinational single-subtract range fold. It is instantiated twice, once for x and once for y.
- The rest is one FSM plus counters.

Test Plan:
- Free first try: GRID 16x16, rand_num=9 on req cycle then 20; occ_hit always 0 → one query at (9,4); done at cycle 4; food=(9,4); food_vld=1.
- Fold boundaries: rand_num=31 with GRID_W=16 → x=15; rand_num=16 → 0; rand_num=15 → 15. With GRID_W=20, rand_num=19 → 19 and 20 → 0.
- Retry: occ_hit=1 for the first two queries, then 0 → exactly 3 queries, each with freshly sampled x and y; done at cycle 10.
- Scan fallback: MAX_TRIES=2; occ_hit=1 everywhere except (0,0); last random candidate (15,15) → scan wraps to (0,0) → food=(0,0); board_full=0.
- Board full: occ_hit always 1 → exactly MAX_TRIES + 256 queries; done pulses once; board_full=1; food_vld=0. A following req clears board_full.
- Reset/ignore: a req during WAIT is ignored (single done). Asserting rst during SCAN_Q → all outputs 0 immediately and no done pulse. A new req after reset completes normally.
